// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road intersection controller with all-red clearance and demand-driven side road
// Optional pedestrian walk phase is built when TL_PED_EN is defined.
module traffic_intersection_ctrl #(
    parameter int CNT_W       = 8,
    parameter int STARTUP_CYC = 32,
    parameter int A_GREEN_CYC = 20,
    parameter int B_GREEN_CYC = 12,
    parameter int YELLOW_CYC  = 7,
    parameter int ALLRED_CYC  = 2,
    parameter int WALK_CYC    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       b_sense,
    input  logic       ped_req,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [2:0] S_STARTUP   = 3'd0;
    localparam logic [2:0] S_A_GREEN   = 3'd1;
    localparam logic [2:0] S_A_YELLOW  = 3'd2;
    localparam logic [2:0] S_ALLRED_AB = 3'd3;
    localparam logic [2:0] S_B_GREEN   = 3'd4;
    localparam logic [2:0] S_B_YELLOW  = 3'd5;
    localparam logic [2:0] S_ALLRED_BA = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_req_q, b_req_d;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_q, walk_d;

    logic [CNT_W-1:0] dur_m1;
    logic [CNT_W-1:0] walk_m1;
    logic             done;
    logic             enter_b;

    assign walk_m1 = CNT_W'(WALK_CYC - 1);

    always_comb begin
        dur_m1 = '0;
        case (state_q)
            S_STARTUP:   dur_m1 = CNT_W'(STARTUP_CYC - 1);
            S_A_GREEN:   dur_m1 = CNT_W'(A_GREEN_CYC - 1);
            S_A_YELLOW:  dur_m1 = CNT_W'(YELLOW_CYC - 1);
            S_ALLRED_AB: dur_m1 = CNT_W'(ALLRED_CYC - 1);
            S_B_GREEN:   dur_m1 = CNT_W'(B_GREEN_CYC - 1);
            S_B_YELLOW:  dur_m1 = CNT_W'(YELLOW_CYC - 1);
            S_ALLRED_BA: dur_m1 = CNT_W'(ALLRED_CYC - 1);
            default:     dur_m1 = '0;
        endcase
    end

    assign done    = (cnt_q == dur_m1);
    assign enter_b = enable && (state_q == S_ALLRED_AB) && done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_STARTUP;
            cnt_q         <= '0;
            b_req_q       <= 1'b0;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            b_req_q       <= b_req_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (enable) begin
            cnt_d = done ? '0 : cnt_q + 1'b1;
            case (state_q)
                S_STARTUP:   if (done) state_d = S_A_GREEN;
                // Without demand the dwell simply restarts: main road rests in green.
                S_A_GREEN:   if (done && (b_req_q || ped_pending_q)) state_d = S_A_YELLOW;
                S_A_YELLOW:  if (done) state_d = S_ALLRED_AB;
                S_ALLRED_AB: if (done) state_d = S_B_GREEN;
                S_B_GREEN:   if (done) state_d = S_B_YELLOW;
                S_B_YELLOW:  if (done) state_d = S_ALLRED_BA;
                S_ALLRED_BA: if (done) state_d = S_A_GREEN;
                default: begin
                    state_d = S_STARTUP;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Requests latch even while paused; entering B_GREEN serves them and wins over a new set.
    always_comb begin
        b_req_d = enter_b ? 1'b0 : (b_req_q | b_sense);
`ifdef TL_PED_EN
        ped_pending_d = enter_b ? 1'b0 : (ped_pending_q | ped_req);
        walk_d        = walk_q;
        if (enable) begin
            if (enter_b) begin
                walk_d = ped_pending_q;
            end else if ((state_q == S_B_GREEN) && ((cnt_q == walk_m1) || done)) begin
                walk_d = 1'b0;
            end
        end
`else
        ped_pending_d = 1'b0;
        walk_d        = 1'b0;
`endif
    end

`ifndef TL_PED_EN
    logic unused_ped;
    assign unused_ped = ped_req ^ (^walk_m1);
`endif

    always_comb begin
        phase       = state_q;
        a_green     = (state_q == S_A_GREEN);
        a_yellow    = (state_q == S_A_YELLOW);
        a_red       = !(a_green || a_yellow);
        b_green     = (state_q == S_B_GREEN);
        b_yellow    = (state_q == S_B_YELLOW);
        b_red       = !(b_green || b_yellow);
        ped_walk    = walk_q;
        ped_pending = ped_pending_q;
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - scoreboard bench with a countdown-based reference model
module tb_traffic_intersection_ctrl;

    localparam int STARTUP_CYC = 32;
    localparam int A_GREEN_CYC = 20;
    localparam int B_GREEN_CYC = 12;
    localparam int YELLOW_CYC  = 7;
    localparam int ALLRED_CYC  = 2;
    localparam int WALK_CYC    = 8;
    localparam int N_CYC       = 2000;
`ifdef TL_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, enable, b_sense, ped_req;
    logic       a_red, a_yellow, a_green, b_red, b_yellow, b_green;
    logic       ped_walk, ped_pending;
    logic [2:0] phase;

    traffic_intersection_ctrl dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .b_sense(b_sense), .ped_req(ped_req),
        .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
        .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
        .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    // Model: phase number, cycles remaining in phase, walk cycles remaining.
    int m_p, m_rem, m_walk;
    bit m_breq, m_ped;
    int n_checks = 0;
    int n_errors = 0;
    logic [10:0] exp_q[$];

    function automatic int dur(input int p);
        case (p)
            0: return STARTUP_CYC;
            1: return A_GREEN_CYC;
            2, 5: return YELLOW_CYC;
            3, 6: return ALLRED_CYC;
            default: return B_GREEN_CYC;
        endcase
    endfunction

    task automatic model_reset();
        m_p = 0; m_rem = STARTUP_CYC; m_walk = 0; m_breq = 0; m_ped = 0;
    endtask

    task automatic model_edge();
        bit nb, np;
        if (!reset_n) begin
            model_reset();
            return;
        end
        nb = m_breq | b_sense;
        np = PED & (m_ped | ped_req);
        if (enable) begin
            if (m_p == 4 && m_walk > 0) m_walk--;
            if (m_rem == 1) begin
                if (m_p == 1 && !(m_breq || m_ped)) begin
                    m_rem = A_GREEN_CYC;
                end else begin
                    m_p   = (m_p == 6) ? 1 : m_p + 1;
                    m_rem = dur(m_p);
                    if (m_p == 4) begin
                        m_walk = m_ped ? WALK_CYC : 0;
                        nb = 0;
                        np = 0;
                    end
                    if (m_p == 5) m_walk = 0;
                end
            end else begin
                m_rem--;
            end
        end
        m_breq = nb;
        m_ped  = np;
    endtask

    function automatic logic [10:0] expected();
        logic [2:0] ph;
        ph = 3'(m_p);
        return {ph, !(m_p == 1 || m_p == 2), m_p == 2, m_p == 1,
                !(m_p == 4 || m_p == 5), m_p == 5, m_p == 4,
                (m_p == 4 && m_walk > 0), m_ped};
    endfunction

    initial begin
        int freeze_left = 0;
        bit done_entry = 0, done_freeze = 0, done_rst = 0;
        reset_n = 1'b0; enable = 1'b1; b_sense = 1'b0; ped_req = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            model_edge();
            #1;
            reset_n = 1'b1; enable = 1'b1; b_sense = 1'b0; ped_req = 1'b0;
            if (cyc < 3) reset_n = 1'b0;
            if (cyc == 240 || cyc == 520 || cyc == 600) b_sense = 1'b1;
            if (cyc == 330) ped_req = 1'b1;
            if (cyc >= 500 && cyc < 800) begin
                if (!done_entry && m_p == 3 && m_rem == 1) begin
                    ped_req = 1'b1;
                    done_entry = 1;
                end
                if (!done_freeze && m_p == 4 && m_rem == 6) begin
                    freeze_left = 10;
                    done_freeze = 1;
                end
                if (!done_rst && done_freeze && m_p == 2 && m_rem == 4) begin
                    reset_n = 1'b0;
                    done_rst = 1;
                end
            end
            if (freeze_left > 0) begin
                enable = 1'b0;
                freeze_left--;
            end
            if (cyc >= 800) begin
                enable  = ($urandom_range(0, 4) != 0);
                b_sense = ($urandom_range(0, 29) == 0);
                ped_req = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 399) == 0) reset_n = 1'b0;
            end
            if (!reset_n) model_reset();
            exp_q.push_back(expected());
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    always @(negedge clk) begin
        logic [10:0] e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {phase, a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk, ped_pending};
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL outputs t=%0t: got phase=%0d lamps=%b walk=%b pend=%b required phase=%0d lamps=%b walk=%b pend=%b",
                         $time, got[10:8], got[7:2], got[1], got[0], e[10:8], e[7:2], e[1], e[0]);
            end
            n_checks++;
            if ($countones({a_red, a_yellow, a_green}) != 1 || $countones({b_red, b_yellow, b_green}) != 1
                || (a_green && b_green)) begin
                n_errors++;
                $display("FAIL lamp_onehot t=%0t: got a=%b b=%b required one lamp per road",
                         $time, {a_red, a_yellow, a_green}, {b_red, b_yellow, b_green});
            end
        end
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
# traffic_intersection_ctrl

Parametrised two-road intersection controller: main road A and side road B, each with red/yellow/green lamps. Adds an all-red clearance interval, demand-driven side-road service from a vehicle sensor, and an optional pedestrian walk phase. Sits in the user project area beside the single-lamp traffic light block and uses the same enable/pause semantics.

## Interface
- CNT_W, 8: dwell counter width; every duration parameter must be ≥1 and ≤ 2^CNT_W.
- STARTUP_CYC, 32: all-red dwell after reset.
- A_GREEN_CYC, 20: minimum main-road green.
- B_GREEN_CYC, 12: side-road green.
- YELLOW_CYC, 7: yellow dwell, both roads.
- ALLRED_CYC, 2: clearance dwell between roads.
- WALK_CYC, 8: walk duration; must be ≤ B_GREEN_CYC.
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  high: dwell counting and transitions advance; low: state and counter freeze.
- b_sense  in  1  side-road vehicle present, level, sampled every cycle.
- ped_req  in  1  pedestrian button, sampled every cycle.
- a_red, a_yellow, a_green  out  1 each  road A lamps.
- b_red, b_yellow, b_green  out  1 each  road B lamps.
- ped_walk  out  1  walk signal across road A.
- ped_pending  out  1  latched, unserved pedestrian request.
- phase  out  3  current state code.

## Operation
- States and codes: STARTUP=0, A_GREEN=1, A_YELLOW=2, ALLRED_AB=3, B_GREEN=4, B_YELLOW=5, ALLRED_BA=6. Code 7 is illegal and goes to STARTUP with the counter cleared on the next enabled edge.
- The dwell counter starts at 0 on state entry. The state exits on the enabled edge where counter == DUR−1, so each state lasts exactly DUR enabled cycles.
- Transitions:
  - STARTUP→A_GREEN.
  - A_GREEN at end of dwell: →A_YELLOW if b_req or ped_pending is set. Otherwise stay in A_GREEN with the counter reset to 0 (rest in main green).
  - A_YELLOW→ALLRED_AB→B_GREEN→B_YELLOW→ALLRED_BA→A_GREEN, unconditionally.
- Lamps:
  - Pure decode of the state register.
  - a_green only in A_GREEN; a_yellow only in A_YELLOW; a_red in all other states. Road B is the mirror.
  - Exactly one lamp per road is lit at all times. Both greens are never lit together.
- Requests:
  - b_sense high sets internal b_req. ped_req high sets ped_pending.
  - Both latch regardless of enable.
  - Both clear on the edge that enters B_GREEN. On that edge, clear has priority over a simultaneous set (the request counts as served).
  - Requests arriving in any other state, including B_GREEN, stay latched for the next cycle.
- ped_walk is high during the first WALK_CYC cycles of B_GREEN, and only if ped_pending was set on entry.

## Timing
- Reset values: phase=0, counter=0, b_req=0, ped_pending=0; a_red=b_red=1; all yellows, greens and ped_walk = 0.
- Reset deassertion mid-cycle has no partial effect. Reset asserted in any state returns to STARTUP immediately.
- Latency: request input to latch, 1 cycle. State register to lamps, 0 cycles.
- With enable low, the counter, state and ped_walk hold, so a walk interval pauses rather than expires.
- Counter arithmetic is CNT_W bits unsigned. It never wraps within a state because of the parameter range rule.
- Minimum request-to-B_GREEN delay from a resting A_GREEN: remainder of the A_GREEN dwell + YELLOW_CYC + ALLRED_CYC.

## Configuration
- TL_PED_EN defined: pedestrian logic as described above.
- TL_PED_EN undefined:
  - ped_req is ignored; ped_pending and ped_walk are tied 0.
  - The A_GREEN exit depends on b_req only.
  - WALK_CYC is unused.

## Test plan
- Reset, enable=1, no requests (defaults) -> all-red for 32 cycles, a_green from cycle 32, then held for 200 cycles with phase=1.
- b_sense high for 1 cycle at cycle 40 -> A_GREEN exits at cycle 52. Then A_YELLOW 7, ALLRED_AB 2, B_GREEN 12, B_YELLOW 7, ALLRED_BA 2 cycles, then back to A_GREEN. b_req is cleared.
- ped_req pulse (TL_PED_EN) -> ped_walk high for exactly the first 8 B_GREEN cycles. ped_pending is cleared on B_GREEN entry.
- ped_req asserted on the B_GREEN entry edge -> not latched. No second B cycle occurs.
- enable low for 10 cycles mid-B_GREEN -> lamps and ped_walk frozen. B_GREEN total active length is still 12 enabled cycles.
- reset_n low mid-A_YELLOW -> immediately a_red=b_red=1, phase=0, latches cleared. The full 32-cycle STARTUP repeats.
